fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit MISC-V pipeline: the producer for the decode stage's `pc_in`/`ir_in`/`IPCP2` inputs and the consumer of decode's branch redirect. Holds the fetch PC and drives a request/acknowledge instruction-memory port that tolerates variable latency. Owns the IF/ID pipeline register, with a one-entry skid buffer for decode stalls and flush on redirect.

---
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MISC-V instruction fetch: fetch PC, req/ack imem port,
// IF/ID register with one-entry skid buffer and redirect flush.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] new_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] pcp2_out,
  output logic [15:0] ir_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] fetch_pc, fetch_nx;
  logic [15:0] target_pc, target_nx;
  logic [15:0] buf_pc, buf_pc_nx;
  logic [15:0] buf_ir, buf_ir_nx;
  logic [15:0] pc_nx, pcp2_nx, ir_nx;
  logic        valid_nx;
  logic [15:0] fetch_inc;
  logic [15:0] buf_inc;

  assign fetch_inc = fetch_pc + 16'd2;
  assign buf_inc   = buf_pc + 16'd2;

  // Request is idle only in HOLD; the reset gate drops it at once.
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nx  = state;
    fetch_nx  = fetch_pc;
    target_nx = target_pc;
    buf_pc_nx = buf_pc;
    buf_ir_nx = buf_ir;
    pc_nx     = pc_out;
    pcp2_nx   = pcp2_out;
    ir_nx     = ir_out;
    valid_nx  = valid_out;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          ir_nx    = NOP_INSTR;
          valid_nx = 1'b0;
          if (imem_ack) begin
            fetch_nx = new_pc;
          end else begin
            target_nx = new_pc;
            state_nx  = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_nx = fetch_inc;
          if (stall) begin
            buf_pc_nx = fetch_pc;
            buf_ir_nx = imem_rdata;
            state_nx  = HOLD;
          end else begin
            pc_nx    = fetch_pc;
            pcp2_nx  = fetch_inc;
            ir_nx    = imem_rdata;
            valid_nx = 1'b1;
          end
        end else if (!stall) begin
          ir_nx    = NOP_INSTR;
          valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_nx = new_pc;
          ir_nx    = NOP_INSTR;
          valid_nx = 1'b0;
          state_nx = FETCH;
        end else if (!stall) begin
          pc_nx    = buf_pc;
          pcp2_nx  = buf_inc;
          ir_nx    = buf_ir;
          valid_nx = 1'b1;
          state_nx = FETCH;
        end
      end
      DISCARD: begin
        ir_nx    = NOP_INSTR;
        valid_nx = 1'b0;
        // The stale word is dropped; a same-cycle redirect wins.
        if (imem_ack) begin
          fetch_nx = redirect ? new_pc : target_pc;
          state_nx = FETCH;
        end else if (redirect) begin
          target_nx = new_pc;
        end
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      target_pc <= 16'h0000;
      buf_pc    <= 16'h0000;
      buf_ir    <= 16'h0000;
      pc_out    <= 16'h0000;
      pcp2_out  <= 16'h0000;
      ir_out    <= NOP_INSTR;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_nx;
      target_pc <= target_nx;
      buf_pc    <= buf_pc_nx;
      buf_ir    <= buf_ir_nx;
      pc_out    <= pc_nx;
      pcp2_out  <= pcp2_nx;
      ir_out    <= ir_nx;
      valid_out <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences,
// and random stall/redirect/latency against a stream-level model.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0002;
  localparam logic [15:0] NOP    = 16'h0F00;
  localparam logic [15:0] KEY    = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] new_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] pc_out;
  logic [15:0] pcp2_out;
  logic [15:0] ir_out;
  logic        valid_out;

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .redirect  (redirect),
    .new_pc    (new_pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc_out    (pc_out),
    .pcp2_out  (pcp2_out),
    .ir_out    (ir_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] np;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] pcp2;
    logic [15:0] ir;
  } vec_t;

  vec_t vecs [13];

  int checks = 0;
  int errors = 0;

  int          fixed_lat = 0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_lat = 0;
  logic [15:0] mem_addr = 16'h0000;

  logic [15:0] exp_pc = RST_PC;
  bit          exp_bubble = 1'b0;
  int          consumed = 0;

  function automatic vec_t mk(
    input logic st, rd, input logic [15:0] np,
    input logic req, input logic [15:0] addr,
    input logic vld, input logic [15:0] pc, pcp2, ir);
    vec_t v;
    v.st = st; v.rd = rd; v.np = np;
    v.req = req; v.addr = addr; v.vld = vld;
    v.pc = pc; v.pcp2 = pcp2; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: memory responds, model consumes, inputs applied.
  task automatic cycle(input logic st, input logic rd,
                       input logic [15:0] np);
    logic ack;
    ack = 1'b0;
    if (mem_busy) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, mem_addr);
    end
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_addr = imem_addr;
        mem_lat  = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end
      if (mem_cnt == mem_lat) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt++;
      end
    end
    imem_ack   = ack;
    imem_rdata = ack ? (mem_addr ^ KEY) : 16'($urandom);
    if (!valid_out) chk("bubble_nop", ir_out, NOP);
    if (rd) begin
      exp_pc     = np;
      exp_bubble = 1'b1;
    end else begin
      exp_bubble = 1'b0;
      if (valid_out && !st) begin
        chk("stream_pc", pc_out, exp_pc);
        chk("stream_pcp2", pcp2_out, exp_pc + 16'd2);
        chk("stream_ir", ir_out, exp_pc ^ KEY);
        exp_pc = exp_pc + 16'd2;
        consumed++;
      end
    end
    stall    = st;
    redirect = rd;
    new_pc   = np;
    @(posedge clk);
    #1;
    if (exp_bubble) chk1("redirect_flush", valid_out, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    new_pc   = 16'h0000;
    imem_ack = 1'b0;
    mem_busy = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_pcp2", pcp2_out, 16'h0000);
    chk("rst_ir", ir_out, NOP);
    chk1("rst_valid", valid_out, 1'b0);
    reset      = 1'b0;
    exp_pc     = RST_PC;
    exp_bubble = 1'b0;
    #1;
    chk1("first_req", imem_req, 1'b1);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 16'h0004, 16'hA5A7);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 16'h0006, 16'hA5A1);
    vecs[2]  = mk(1, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'hA5A1);
    vecs[3]  = mk(1, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'hA5A1);
    vecs[4]  = mk(1, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h0006, 16'hA5A1);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0006, 16'h0008, 16'hA5A3);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 16'h000A, 1, 16'h0008, 16'h000A, 16'hA5AD);
    vecs[7]  = mk(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0008, 16'h000A, NOP);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040, 16'h0042, 16'hA5E5);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 16'h0044, 1, 16'h0040, 16'h0042, 16'hA5E5);
    vecs[10] = mk(1, 1, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0040, 16'h0042, NOP);
    vecs[11] = mk(0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h5A5B);
    vecs[12] = mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h0002, 16'hA5A5);

    fixed_lat = 0;
    do_reset(2);
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].st, vecs[i].rd, vecs[i].np);
      chk1($sformatf("v%0d_req", i), imem_req, vecs[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk1($sformatf("v%0d_valid", i), valid_out, vecs[i].vld);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_pcp2", i), pcp2_out, vecs[i].pcp2);
      chk($sformatf("v%0d_ir", i), ir_out, vecs[i].ir);
    end

    // Redirect while a slow request is outstanding.
    do_reset(1);
    cycle(0, 1, 16'h0010);
    chk("lat_addr0", imem_addr, 16'h0010);
    fixed_lat = 2;
    cycle(0, 0, 16'h0000);
    chk("lat_addr1", imem_addr, 16'h0010);
    chk1("lat_valid1", valid_out, 1'b0);
    cycle(0, 1, 16'h0040);
    chk1("disc_req", imem_req, 1'b1);
    chk("disc_addr", imem_addr, 16'h0010);
    cycle(0, 0, 16'h0000);
    chk("disc_next_addr", imem_addr, 16'h0040);
    chk1("disc_valid", valid_out, 1'b0);
    cycle(0, 0, 16'h0000);
    chk1("slow_v0", valid_out, 1'b0);
    chk("slow_ir0", ir_out, NOP);
    cycle(0, 0, 16'h0000);
    chk1("slow_v1", valid_out, 1'b0);
    chk("slow_addr1", imem_addr, 16'h0040);
    cycle(0, 0, 16'h0000);
    chk1("slow_pulse", valid_out, 1'b1);
    chk("slow_pc", pc_out, 16'h0040);
    chk("slow_ir", ir_out, 16'hA5E5);
    chk("slow_addr2", imem_addr, 16'h0042);
    cycle(0, 0, 16'h0000);
    chk1("slow_after", valid_out, 1'b0);
    chk("slow_after_ir", ir_out, NOP);

    // Reset in the middle of an outstanding request.
    cycle(0, 0, 16'h0000);
    do_reset(1);

    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic st, rd;
      logic [15:0] np;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 11) == 0);
      np = ($urandom_range(0, 3) == 0) ?
           16'hFFF8 + 16'($urandom_range(0, 3) * 2) : 16'($urandom);
      cycle(st, rd, np);
    end
    checks++;
    if (consumed < 200) begin
      errors++;
      $display("FAIL throughput: got %0d instructions expected >= 200",
               consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
